// File: rtl/add_accumulator.sv
// add_accumulator: sums SAMPLE_COUNT 8-bit operands per frame, then
// holds the result behind a valid/ready handshake.
// Ports: clk, n_rst (async, active-low), clear (sync frame abort),
//   in_valid/in_data/in_ready (operand input handshake),
//   out_valid/out_ready (result handshake), acc_sum, overflow, count.
// Build option: ADD_ACCUMULATOR_SATURATE_EN clamps acc_sum to 8'hFF
//   from the first carry-out until the frame ends.
module add_accumulator #(
   parameter int SAMPLE_COUNT = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       clear,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] acc_sum,
   output logic       overflow,
   output logic [3:0] count
);

   if (SAMPLE_COUNT < 1 || SAMPLE_COUNT > 15) begin : g_bad_cfg
      $error("SAMPLE_COUNT must be within 1..15");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] LAST = 4'(SAMPLE_COUNT);

   state_t     state_q, state_d;
   logic [7:0] acc_q, acc_d;
   logic       ov_q, ov_d;
   logic [3:0] cnt_q, cnt_d;

   logic       accept;
   logic [8:0] sum9;
   logic [3:0] cnt_inc;
   logic [7:0] acc_add;

   assign in_ready  = (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign acc_sum   = acc_q;
   assign overflow  = ov_q;
   assign count     = cnt_q;

   assign accept  = in_valid && in_ready;
   assign sum9    = {1'b0, acc_q} + {1'b0, in_data};
   assign cnt_inc = cnt_q + 4'd1;

`ifdef ADD_ACCUMULATOR_SATURATE_EN
   // Sticky overflow keeps the sum pinned even if a
   // later operand would not carry on its own.
   assign acc_add = (ov_q || sum9[8]) ? 8'hFF : sum9[7:0];
`else
   assign acc_add = sum9[7:0];
`endif

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ov_d    = ov_q;
      cnt_d   = cnt_q;
      if (clear) begin
         state_d = IDLE;
         acc_d   = 8'h00;
         ov_d    = 1'b0;
         cnt_d   = 4'h0;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc_d   = acc_add;
                  ov_d    = ov_q | sum9[8];
                  cnt_d   = cnt_inc;
                  state_d = (cnt_inc == LAST) ? DONE : ACCUM;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
                  acc_d   = 8'h00;
                  ov_d    = 1'b0;
                  cnt_d   = 4'h0;
               end
            end
            default: begin
               state_d = IDLE;
               acc_d   = 8'h00;
               ov_d    = 1'b0;
               cnt_d   = 4'h0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         acc_q   <= 8'h00;
         ov_q    <= 1'b0;
         cnt_q   <= 4'h0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ov_q    <= ov_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: doc/add_accumulator.md
ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 Parameter: SAMPLE_COUNT, default 8, number of operands summed per frame; legal range 1..15.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: n_rst  input  1  asynchronous, active-low reset.
REQ-004 Port: clear  input  1  synchronous frame abort; highest priority after n_rst.
REQ-005 Port: in_valid  input  1  upstream operand valid.
REQ-006 Port: in_data  input  8  unsigned operand.
REQ-007 Port: in_ready  output  1  block can accept an operand this cycle.
REQ-008 Port: out_valid  output  1  frame result available.
REQ-009 Port: out_ready  input  1  downstream accepts result.
REQ-010 Port: acc_sum  output  8  running/final 8-bit sum.
REQ-011 Port: overflow  output  1  sticky carry-out of any accumulation step in current frame.
REQ-012 Port: count  output  4  operands accepted in current frame.

Function
REQ-013 FSM states SHALL be IDLE, ACCUM, DONE; all outputs driven from registers or decoded state only.
REQ-014 in_ready SHALL be 1 in IDLE and ACCUM, 0 in DONE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept = in_valid && in_ready; on accept, acc_sum <= acc_sum + in_data (9-bit add, low 8 bits kept), count <= count + 1.
REQ-016 On accept, overflow SHALL be set if bit 8 of the 9-bit add is 1; once set it SHALL hold until frame end, clear or reset.
REQ-017 IDLE -> ACCUM on first accept when SAMPLE_COUNT > 1; IDLE -> DONE on first accept when SAMPLE_COUNT = 1.
REQ-018 ACCUM -> DONE on the accept that makes count equal SAMPLE_COUNT; out_valid asserts the next cycle (1-cycle latency from last accept).
REQ-019 ACCUM with in_valid = 0 SHALL hold all state; no timeout.
REQ-020 DONE SHALL hold acc_sum, overflow, count stable while out_ready = 0.
REQ-021 DONE with out_ready = 1: next cycle state IDLE, acc_sum = 0, overflow = 0, count = 0; in_ready = 0 during the handshake cycle, so no operand is accepted in the same cycle.
REQ-022 clear = 1 in any state: next cycle state IDLE, acc_sum = 0, overflow = 0, count = 0; a simultaneous accept or out handshake SHALL be discarded.
REQ-023 Operands arriving back-to-back (in_valid held high) SHALL be accepted one per cycle.

Reset
REQ-024 n_rst = 0 SHALL immediately force state IDLE, acc_sum = 8'h00, overflow = 0, count = 4'h0, out_valid = 0, in_ready = 1 (in_ready is decoded from state).
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; first edge after deassertion behaves as IDLE.

Configuration
REQ-026 Macro ADD_ACCUMULATOR_SATURATE_EN defined: on an accept whose 9-bit add has bit 8 = 1, acc_sum SHALL become 8'hFF and remain 8'hFF for further accepts in that frame; overflow still set.
REQ-027 Macro undefined: acc_sum SHALL wrap modulo 256 per REQ-015.

Verification
REQ-028 Reset, then SAMPLE_COUNT = 8, operands 1..8 back-to-back, out_ready = 1 -> out_valid one cycle after 8th accept, acc_sum = 8'd36, overflow = 0, count = 8; IDLE with zeros the next cycle.
REQ-029 Operands 8'hF0, 8'h20, then six 8'h00 -> overflow = 1; acc_sum = 8'h10 without macro, 8'hFF with ADD_ACCUMULATOR_SATURATE_EN.
REQ-030 Complete frame, out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0, acc_sum/count unchanged; out_ready = 1 -> frame clears, next operand accepted the cycle after.
REQ-031 Accept 3 operands (10, 20, 30), then assert clear together with in_valid = 1 -> acc_sum = 0, count = 0, state IDLE; 4th operand not counted.
REQ-032 Accept 5 operands, pulse n_rst low between edges -> outputs zero immediately; following 8-operand frame of 8'h02 gives acc_sum = 8'd16.
REQ-033 SAMPLE_COUNT = 1, operand 8'h7F -> out_valid next cycle, acc_sum = 8'h7F, count = 1.
